// File: rtl/ysyx_040066_bus_pkg.sv
// Shared definitions for the cache-side memory bus arbiter.
package ysyx_040066_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } arb_state_e;

    localparam int unsigned BUS_AW    = 64;
    localparam int unsigned BUS_DW    = 64;
    localparam int unsigned BUS_LW    = 512;
    localparam int unsigned BUS_LENW  = 3;
    localparam int unsigned BUS_MASKW = 8;

    // Index width for an n-entry vector; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ysyx_040066_rr_pick.sv
// Rotate-priority picker: first requester at index >= rr, wrapping.
module ysyx_040066_rr_pick
    import ysyx_040066_bus_pkg::*;
#(
    parameter int unsigned NCH = 2,
    localparam int unsigned IW = idx_w(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  rr,
    output logic [NCH-1:0] win_oh,
    output logic [IW-1:0]  win_idx,
    output logic           win_vld
);

    int unsigned pos;

    // Scan NCH slots starting at rr; the first hit wins.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        pos     = 0;
        for (int unsigned k = 0; k < NCH; k++) begin
            pos = 32'(rr) + k;
            if (pos >= NCH) begin
                pos = pos - NCH;
            end
            if (!win_vld && req[IW'(pos)]) begin
                win_vld              = 1'b1;
                win_idx              = IW'(pos);
                win_oh[IW'(pos)]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ysyx_040066_mem_arbiter.sv
// N-master arbiter merging per-master read/write channels onto one memory bus.
module ysyx_040066_mem_arbiter
    import ysyx_040066_bus_pkg::*;
#(
    parameter int unsigned NCH     = 2,
    parameter int unsigned AW      = BUS_AW,
    parameter int unsigned DW      = BUS_DW,
    parameter int unsigned LW      = BUS_LW,
    parameter int unsigned LENW    = BUS_LENW,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic               clk,
    input  logic               rst,

    input  logic [NCH-1:0]      m_rd_req,
    input  logic [NCH-1:0]      m_rd_burst,
    input  logic [NCH*LENW-1:0] m_rd_len,
    input  logic [NCH*AW-1:0]   m_rd_addr,
    output logic [NCH-1:0]      m_rd_ready,
    output logic [NCH-1:0]      m_rd_last,
    output logic [NCH-1:0]      m_rd_err,
    output logic [DW-1:0]       m_rd_data,

    input  logic [NCH-1:0]      m_wr_req,
    input  logic [NCH-1:0]      m_wr_burst,
    input  logic [NCH*LENW-1:0] m_wr_len,
    input  logic [NCH*8-1:0]    m_wr_mask,
    input  logic [NCH*AW-1:0]   m_wr_addr,
    input  logic [NCH*LW-1:0]   m_wr_data,
    output logic [NCH-1:0]      m_wr_ready,
    output logic [NCH-1:0]      m_wr_err,

    output logic                rd_req,
    output logic                rd_burst,
    output logic [LENW-1:0]     rd_len,
    output logic [AW-1:0]       rd_addr,
    input  logic                rd_ready,
    input  logic                rd_last,
    input  logic                rd_err,
    input  logic [DW-1:0]       rd_data,

    output logic                wr_req,
    output logic                wr_burst,
    output logic [LENW-1:0]     wr_len,
    output logic [7:0]          wr_mask,
    output logic [AW-1:0]       wr_addr,
    output logic [LW-1:0]       wr_data,
    input  logic                wr_ready,
    input  logic                wr_err,

    output logic                busy,
    output logic [NCH-1:0]      grant
);

    localparam int unsigned IW      = idx_w(NCH);
    localparam int unsigned MW      = BUS_MASKW;
    localparam bit          WD_EN   = (TIMEOUT > 0);
    localparam int unsigned WDW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned WD_LAST = WD_EN ? (TIMEOUT - 1) : 0;

    typedef struct packed {
        logic            burst;
        logic [LENW-1:0] len;
        logic [AW-1:0]   addr;
    } rd_cmd_t;

    typedef struct packed {
        logic            burst;
        logic [LENW-1:0] len;
        logic [MW-1:0]   mask;
        logic [AW-1:0]   addr;
        logic [LW-1:0]   data;
    } wr_cmd_t;

    arb_state_e      state, state_nx;
    logic [IW-1:0]   rr;
    logic [IW-1:0]   owner;
    logic [NCH-1:0]  grant_q;
    rd_cmd_t         rd_cmd_q;
    wr_cmd_t         wr_cmd_q;
    logic [WDW-1:0]  wd_cnt;

    rd_cmd_t         rd_cmd_a [NCH];
    wr_cmd_t         wr_cmd_a [NCH];

    logic [NCH-1:0]  pick_oh;
    logic [IW-1:0]   pick_idx;
    logic            pick_vld;
    logic            pick_wr_c;
    logic            dn_ready_c;
    logic            rd_done_c;
    logic            wr_done_c;
    logic            wd_fire_c;

    // Unpack the flat per-master buses into command records.
    for (genvar g = 0; g < NCH; g++) begin : g_unpack
        assign rd_cmd_a[g] = '{burst: m_rd_burst[g],
                               len:   m_rd_len[g*LENW +: LENW],
                               addr:  m_rd_addr[g*AW +: AW]};
        assign wr_cmd_a[g] = '{burst: m_wr_burst[g],
                               len:   m_wr_len[g*LENW +: LENW],
                               mask:  m_wr_mask[g*MW +: MW],
                               addr:  m_wr_addr[g*AW +: AW],
                               data:  m_wr_data[g*LW +: LW]};
    end

    ysyx_040066_rr_pick #(.NCH(NCH)) u_pick (
        .req     (m_rd_req | m_wr_req),
        .rr      (rr),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .win_vld (pick_vld)
    );

    // Writeback precedes refill when the winner has both requests up.
    assign pick_wr_c  = m_wr_req[pick_idx];

    // Completion and watchdog conditions for the current owner.
    assign dn_ready_c = ((state == ST_RD) && rd_ready) || ((state == ST_WR) && wr_ready);
    assign rd_done_c  = (state == ST_RD) && rd_ready && (rd_last || rd_err);
    assign wr_done_c  = (state == ST_WR) && wr_ready;
    assign wd_fire_c  = WD_EN && (state != ST_IDLE) && !dn_ready_c && (wd_cnt == WDW'(WD_LAST));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and per-master response routing to the owner only.
    always_comb begin
        state_nx   = state;
        m_rd_ready = '0;
        m_rd_last  = '0;
        m_rd_err   = '0;
        m_wr_ready = '0;
        m_wr_err   = '0;
        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_nx = pick_wr_c ? ST_WR : ST_RD;
                end
            end
            ST_RD: begin
                m_rd_ready = grant_q & {NCH{rd_ready | wd_fire_c}};
                m_rd_last  = grant_q & {NCH{rd_last  | wd_fire_c}};
                m_rd_err   = grant_q & {NCH{rd_err   | wd_fire_c}};
                if (rd_done_c || wd_fire_c) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_WR: begin
                m_wr_ready = grant_q & {NCH{wr_ready | wd_fire_c}};
                m_wr_err   = grant_q & {NCH{wr_err   | wd_fire_c}};
                if (wr_done_c || wd_fire_c) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Latch the winning command at grant; rotate rr past the owner on completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr       <= '0;
            owner    <= '0;
            grant_q  <= '0;
            rd_cmd_q <= '0;
            wr_cmd_q <= '0;
        end else if ((state == ST_IDLE) && pick_vld) begin
            owner   <= pick_idx;
            grant_q <= pick_oh;
            if (pick_wr_c) begin
                wr_cmd_q <= wr_cmd_a[pick_idx];
            end else begin
                rd_cmd_q <= rd_cmd_a[pick_idx];
            end
        end else if (rd_done_c || wr_done_c || wd_fire_c) begin
            grant_q <= '0;
            rr      <= ((32'(owner) + 1) >= NCH) ? '0 : (owner + IW'(1));
        end
    end

    // Watchdog: cycles in a transaction since the last downstream ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if ((state == ST_IDLE) || dn_ready_c || wd_fire_c) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WDW'(1);
        end
    end

    // Downstream command driven from the latched registers.
    assign rd_req    = (state == ST_RD);
    assign rd_burst  = rd_cmd_q.burst;
    assign rd_len    = rd_cmd_q.len;
    assign rd_addr   = rd_cmd_q.addr;

    assign wr_req    = (state == ST_WR);
    assign wr_burst  = wr_cmd_q.burst;
    assign wr_len    = wr_cmd_q.len;
    assign wr_mask   = wr_cmd_q.mask;
    assign wr_addr   = wr_cmd_q.addr;
    assign wr_data   = wr_cmd_q.data;

    assign m_rd_data = (state == ST_RD) ? rd_data : '0;
    assign busy      = (state != ST_IDLE);
    assign grant     = grant_q;

endmodule

// File: tb/tb_ysyx_040066_mem_arbiter.sv
// Directed bench for the memory bus arbiter (NCH=2, TIMEOUT=16).
module tb_ysyx_040066_mem_arbiter;

    localparam int unsigned NCH  = 2;
    localparam int unsigned AW   = 64;
    localparam int unsigned DW   = 64;
    localparam int unsigned LW   = 512;
    localparam int unsigned LENW = 3;
    localparam int unsigned TO   = 16;

    logic clk;
    logic rst;

    logic [NCH-1:0]      m_rd_req, m_rd_burst;
    logic [NCH*LENW-1:0] m_rd_len;
    logic [NCH*AW-1:0]   m_rd_addr;
    logic [NCH-1:0]      m_rd_ready, m_rd_last, m_rd_err;
    logic [DW-1:0]       m_rd_data;
    logic [NCH-1:0]      m_wr_req, m_wr_burst;
    logic [NCH*LENW-1:0] m_wr_len;
    logic [NCH*8-1:0]    m_wr_mask;
    logic [NCH*AW-1:0]   m_wr_addr;
    logic [NCH*LW-1:0]   m_wr_data;
    logic [NCH-1:0]      m_wr_ready, m_wr_err;
    logic                rd_req, rd_burst;
    logic [LENW-1:0]     rd_len;
    logic [AW-1:0]       rd_addr;
    logic                rd_ready, rd_last, rd_err;
    logic [DW-1:0]       rd_data;
    logic                wr_req, wr_burst;
    logic [LENW-1:0]     wr_len;
    logic [7:0]          wr_mask;
    logic [AW-1:0]       wr_addr;
    logic [LW-1:0]       wr_data;
    logic                wr_ready, wr_err;
    logic                busy;
    logic [NCH-1:0]      grant;

    int n_cmp;
    int n_err;

    ysyx_040066_mem_arbiter #(
        .NCH(NCH), .AW(AW), .DW(DW), .LW(LW), .LENW(LENW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .m_rd_req(m_rd_req), .m_rd_burst(m_rd_burst), .m_rd_len(m_rd_len),
        .m_rd_addr(m_rd_addr), .m_rd_ready(m_rd_ready), .m_rd_last(m_rd_last),
        .m_rd_err(m_rd_err), .m_rd_data(m_rd_data),
        .m_wr_req(m_wr_req), .m_wr_burst(m_wr_burst), .m_wr_len(m_wr_len),
        .m_wr_mask(m_wr_mask), .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data),
        .m_wr_ready(m_wr_ready), .m_wr_err(m_wr_err),
        .rd_req(rd_req), .rd_burst(rd_burst), .rd_len(rd_len), .rd_addr(rd_addr),
        .rd_ready(rd_ready), .rd_last(rd_last), .rd_err(rd_err), .rd_data(rd_data),
        .wr_req(wr_req), .wr_burst(wr_burst), .wr_len(wr_len), .wr_mask(wr_mask),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready), .wr_err(wr_err),
        .busy(busy), .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: sim still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NCH-1:0] oh(input int m);
        return NCH'(1) << m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req_rd(input int m, input logic [AW-1:0] addr, input int nb);
        m_rd_req[m]                = 1'b1;
        m_rd_burst[m]              = (nb > 1);
        m_rd_len[m*LENW +: LENW]   = LENW'(nb - 1);
        m_rd_addr[m*AW +: AW]      = addr;
    endtask

    // Wait for the downstream read, feed nb beats, check routing and the bubble.
    task automatic serve_rd(input int own, input logic [AW-1:0] addr, input int nb, input bit drop_early);
        int w;
        int p_own;
        int p_oth;
        logic [NCH-1:0] exp_last;
        w = 0;
        while (!rd_req && w < 16) begin
            step();
            w++;
        end
        check("rd_req_up", rd_req, 1);
        check("rd_grant", grant, oh(own));
        check("rd_busy", busy, 1);
        check("rd_addr", rd_addr, addr);
        check("rd_len", rd_len, nb - 1);
        check("rd_burst", rd_burst, (nb > 1));
        if (drop_early) begin
            m_rd_req[own]           = 1'b0;
            m_rd_addr[own*AW +: AW] = '1;
        end
        p_own = 0;
        p_oth = 0;
        for (int i = 0; i < nb; i++) begin
            rd_ready = 1'b1;
            rd_last  = (i == nb - 1);
            rd_data  = {32'(i) ^ 32'hD00D_0000, addr[31:0]};
            #1;
            if (m_rd_ready == oh(own)) p_own++;
            if ((m_rd_ready & ~oh(own)) != '0) p_oth++;
            exp_last = (i == nb - 1) ? oh(own) : '0;
            check("rd_last_route", m_rd_last, exp_last);
            check("rd_data_bcast", m_rd_data, rd_data);
            check("rd_addr_hold", {rd_req, rd_addr}, {1'b1, addr});
            step();
        end
        rd_ready      = 1'b0;
        rd_last       = 1'b0;
        m_rd_req[own] = 1'b0;
        check("rd_beats_owner", p_own, nb);
        check("rd_beats_other", p_oth, 0);
        check("rd_bubble", {busy, rd_req, grant}, 0);
    endtask

    initial begin
        int early;
        n_cmp = 0;
        n_err = 0;
        rst        = 1'b0;
        m_rd_req   = '0; m_rd_burst = '0; m_rd_len = '0; m_rd_addr = '0;
        m_wr_req   = '0; m_wr_burst = '0; m_wr_len = '0; m_wr_mask = '0;
        m_wr_addr  = '0; m_wr_data  = '0;
        rd_ready   = 1'b0; rd_last = 1'b0; rd_err = 1'b0; rd_data = '0;
        wr_ready   = 1'b0; wr_err  = 1'b0;

        // Reset state
        step();
        step();
        check("rst_ctrl", {busy, grant, rd_req, wr_req}, 0);
        check("rst_resp", {m_rd_ready, m_rd_last, m_rd_err, m_wr_ready, m_wr_err}, 0);
        check("rst_cmd", {rd_addr, rd_len, wr_addr, wr_mask}, 0);
        rst = 1'b1;

        // Master 1 eight-beat burst read
        req_rd(1, 64'h8000_0040, 8);
        serve_rd(1, 64'h8000_0040, 8, 1'b0);

        // Round-robin between two reading masters
        rst = 1'b0;
        step();
        rst = 1'b1;
        req_rd(0, 64'h0000_0100, 2);
        req_rd(1, 64'h0000_0200, 3);
        serve_rd(0, 64'h0000_0100, 2, 1'b0);
        serve_rd(1, 64'h0000_0200, 3, 1'b0);
        req_rd(0, 64'h0000_0110, 1);
        req_rd(1, 64'h0000_0210, 1);
        serve_rd(0, 64'h0000_0110, 1, 1'b0);
        serve_rd(1, 64'h0000_0210, 1, 1'b0);

        // Master 1 writeback and refill together: write goes first
        m_wr_data[0*LW +: LW] = {64{8'h5A}};
        m_wr_mask[0*8 +: 8]   = 8'h0F;
        m_wr_req[1]           = 1'b1;
        m_wr_burst[1]         = 1'b1;
        m_wr_len[1*LENW +: LENW] = 3'd7;
        m_wr_mask[1*8 +: 8]   = 8'hFF;
        m_wr_addr[1*AW +: AW] = 64'h0000_3000;
        m_wr_data[1*LW +: LW] = {64{8'hA5}};
        req_rd(1, 64'h0000_4000, 1);
        step();
        check("wr_first", {wr_req, rd_req, grant}, {1'b1, 1'b0, 2'b10});
        check("wr_addr", wr_addr, 64'h0000_3000);
        check("wr_data", wr_data, {64{8'hA5}});
        check("wr_mask", {wr_burst, wr_len, wr_mask}, {1'b1, 3'd7, 8'hFF});
        check("wr_wait", {m_wr_ready, m_wr_err}, 0);
        step();
        wr_ready = 1'b1;
        #1;
        check("wr_done_route", {m_wr_ready, m_wr_err}, {2'b10, 2'b00});
        step();
        wr_ready    = 1'b0;
        m_wr_req[1] = 1'b0;
        check("wr_bubble", {busy, wr_req, rd_req}, 0);
        serve_rd(1, 64'h0000_4000, 1, 1'b0);

        // Master 0 drops its request after grant
        req_rd(0, 64'h0000_5000, 4);
        serve_rd(0, 64'h0000_5000, 4, 1'b1);

        // Watchdog: downstream never answers master 1
        req_rd(0, 64'h0000_6000, 1);
        req_rd(1, 64'h0000_7000, 1);
        step();
        check("to_grant", grant, 2'b10);
        early = 0;
        for (int c = 1; c <= int'(TO); c++) begin
            if (c < int'(TO)) begin
                if ((m_rd_ready | m_rd_err | m_rd_last) != '0) early++;
            end else begin
                check("to_fire", {m_rd_ready, m_rd_err, m_rd_last}, {2'b10, 2'b10, 2'b10});
                check("to_req_held", rd_req, 1);
            end
            step();
        end
        check("to_early", early, 0);
        check("to_drop", {busy, rd_req}, 0);
        m_rd_req[1] = 1'b0;
        serve_rd(0, 64'h0000_6000, 1, 1'b0);

        // Reset on beat 3 of a burst, then re-arbitrate from rr=0
        req_rd(0, 64'h0000_A000, 1);
        req_rd(1, 64'h0000_B000, 8);
        step();
        check("rm_grant", grant, 2'b10);
        rd_ready = 1'b1;
        step();
        step();
        #1;
        rst = 1'b0;
        #1;
        check("rm_outputs", {busy, rd_req, wr_req, grant, m_rd_ready, m_rd_last, m_rd_err}, 0);
        rd_ready = 1'b0;
        step();
        rst = 1'b1;
        serve_rd(0, 64'h0000_A000, 1, 1'b0);
        serve_rd(1, 64'h0000_B000, 8, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
